sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Time-shares the single external 256Kx16 SRAM between three requesters:
  - the VGA scan-out read port (highest priority);
  - a full-screen clear sequencer;
  - the triangle/pixel draw write port (lowest priority).
- Owns every SRAM pin and the DQ tristate. No other block drives SRAM_* directly.
- Sits between the VGA timing/pixel path and the rasteriser.

Parameters:
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- CLEAR_DEPTH, 262144, number of words written by one clear (addresses 0..CLEAR_DEPTH-1).

Ports:
- CLOCK_50  in  1  single system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- vid_req  in  1  one-cycle read request from the VGA path.
- vid_addr  in  ADDR_W  read address, sampled with vid_req.
- vid_data  out  DATA_W  read data, valid when vid_valid=1.
- vid_valid  out  1  one-cycle pulse marking vid_data.
- vid_ovf  out  1  sticky: a vid_req was dropped.
- wr_valid  in  1  draw write request; must be held until accepted.
- wr_addr  in  ADDR_W  draw write address.
- wr_data  in  DATA_W  draw write data (12-bit colour in [11:0]).
- wr_ready  out  1  a write transfers when wr_valid&&wr_ready.
- clr_start  in  1  pulse: start clearing the screen.
- clr_color  in  DATA_W  fill value, sampled on an accepted clr_start.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- SRAM_ADDR  out  ADDR_W  SRAM address.
- SRAM_DQ  inout  DATA_W  SRAM data bus.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N  out  1  chip enable, active low.
- SRAM_UB_N  out  1  upper byte enable, active low.
- SRAM_LB_N  out  1  lower byte enable, active low.

Behaviour:
- All SRAM_* outputs and the DQ output-enable are registered.
- CE_N, UB_N and LB_N are constant 0 after reset.
- State machine states: IDLE, READ, WR1, WR2.
  - IDLE and READ: WE_N=1. OE_N=0 only in READ. DQ is high-Z.
  - WR1: WE_N=0, OE_N=1. SRAM_ADDR and DQ driven with the granted write.
  - WR2: WE_N=1. Address and DQ held for one cycle (hold time); DQ driven.
  - WR1 always goes to WR2.
- Arbitration slot: any cycle whose state is IDLE, READ or WR2. The winner's operation occupies the next cycle. With no winner, next state is IDLE.
- Priority, highest first:
  1. Video: vid_req or vid_pend.
  2. Clear: clr_busy.
  3. Draw: wr_valid.
- Video pending register:
  - A vid_req that lands in a WR1 cycle, or loses nothing but arrives during WR1, is latched into vid_pend with its address.
  - It is served at the next slot.
  - A vid_req arriving while vid_pend=1 is dropped and sets vid_ovf. vid_ovf clears only on reset.
  - A requester that spaces requests 2 or more cycles apart never overflows.
- Read latency:
  - vid_req in cycle N at a slot: READ in N+1, data captured from SRAM_DQ at the end of N+1, vid_valid=1 and vid_data in N+2.
  - If N is a WR1 cycle, vid_valid is at N+3.
  - Maximum read latency is 3 cycles.
- wr_ready is combinational and equals: slot cycle && !vid_req && !vid_pend && !clr_busy && !reset. A write is accepted only when it wins the slot.
- Write throughput: one write per 2 cycles when uncontended.
- Read-after-write: WR2 then READ. DQ is released at the READ cycle's edge, giving no bus contention.
- Clear sequencer:
  - A clr_start with clr_busy=0 sets clr_busy=1, clears the address counter to 0, and latches clr_color.
  - clr_start while busy is ignored.
  - Each clear write uses WR1/WR2 at the counter address, then increments the counter.
  - In the WR2 cycle of address CLEAR_DEPTH-1: clr_busy drops to 0 next cycle and clr_done pulses one cycle.
  - Video reads preempt the clear between words; a clear word is never split.
- Draw data bits [15:12] are written as given; the arbiter does no masking.
- Reset values:
  - State IDLE; WE_N=1, OE_N=1, CE_N=0, UB_N=0, LB_N=0.
  - SRAM_ADDR=0, DQ high-Z.
  - vid_valid=0, vid_data=0, vid_pend=0, vid_ovf=0.
  - clr_busy=0, clr_done=0, wr_ready=0.
- Reset mid-operation:
  - An in-flight write is abandoned. WE_N returns to 1 at the reset edge, so a partial word is possible and acceptable.
  - A clear in progress aborts with no clr_done.
  - A pending read is discarded with no vid_valid.

Test Plan:
- Single read: after reset, vid_req with vid_addr=0x00123 and an SRAM model holding 0x0ABC -> OE_N=0 and ADDR=0x00123 in N+1; vid_valid=1 with vid_data=0x0ABC in N+2.
- Single write: wr_valid with addr=0x00040, data=0x000F in an idle cycle -> wr_ready=1; WE_N=0 for exactly 1 cycle with DQ=0x000F, then a 1-cycle hold; the model holds 0x000F; DQ high-Z afterwards.
- Contention: wr_valid held, then vid_req in the WR1 cycle -> wr_ready=0 until the read is served; vid_valid 3 cycles after the request; the write completes afterwards with no lost data.
- Clear with CLEAR_DEPTH=8 and clr_color=0x0FF0 -> 8 writes to addresses 0..7; clr_busy high throughout; exactly one clr_done pulse; wr_ready=0 while busy; a second clr_start while busy is ignored.
- Overflow: vid_req in two consecutive cycles during WR1 -> the second is dropped, vid_ovf=1 and stays 1 until reset.
- Reset mid-clear at address 3 -> next cycle clr_busy=0, no clr_done, WE_N=1, DQ high-Z, all outputs at reset values.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: time-shares one async 256Kx16 SRAM between video reads, a screen-clear
// sequencer and draw writes; all SRAM pins and the DQ enable come straight from flops.
module sram_arbiter #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int CLEAR_DEPTH = 262144
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic              vid_ovf,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_WE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] WR1  = 2'd2;
    localparam logic [1:0] WR2  = 2'd3;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_out_q, dq_out_d;
    logic              dq_oe_q, dq_oe_d;
    logic              we_n_q, we_n_d;
    logic              oe_n_q, oe_n_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic              vid_valid_q, vid_valid_d;
    logic              vid_pend_q, vid_pend_d;
    logic [ADDR_W-1:0] vid_paddr_q, vid_paddr_d;
    logic              vid_ovf_q, vid_ovf_d;
    logic              clr_busy_q, clr_busy_d;
    logic              clr_done_q, clr_done_d;
    logic              clr_all_q, clr_all_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] clr_color_q, clr_color_d;
    logic              wr_clr_q, wr_clr_d;
    logic              slot, vid_go, clr_go, wr_go, clr_fin, clr_ok;

    always_comb begin
        slot        = state_q != WR1;
        vid_go      = slot && (vid_req || vid_pend_q);
        clr_go      = slot && !vid_go && clr_busy_q && !clr_all_q;
        wr_ready    = slot && !vid_req && !vid_pend_q && !clr_busy_q && !reset;
        wr_go       = wr_valid && wr_ready;
        // clr_all_q marks that the last word has been issued; its hold cycle ends the clear
        clr_fin     = state_q == WR2 && wr_clr_q && clr_all_q;
        clr_ok      = clr_start && !clr_busy_q;
        state_d     = vid_go ? READ : (clr_go || wr_go) ? WR1 : !slot ? WR2 : IDLE;
        addr_d      = vid_go ? (vid_pend_q ? vid_paddr_q : vid_addr)
                    : clr_go ? clr_cnt_q : wr_go ? wr_addr : addr_q;
        dq_out_d    = clr_go ? clr_color_q : wr_go ? wr_data : dq_out_q;
        dq_oe_d     = state_d == WR1 || state_d == WR2;
        we_n_d      = state_d != WR1;
        oe_n_d      = state_d != READ;
        wr_clr_d    = slot ? clr_go : wr_clr_q;
        vid_pend_d  = vid_pend_q ? !slot : vid_req && !slot;
        vid_paddr_d = (!vid_pend_q && vid_req && !slot) ? vid_addr : vid_paddr_q;
        vid_ovf_d   = vid_ovf_q || (vid_req && vid_pend_q);
        vid_valid_d = state_q == READ;
        vid_data_d  = state_q == READ ? SRAM_DQ : vid_data_q;
        clr_busy_d  = clr_ok || (clr_busy_q && !clr_fin);
        clr_done_d  = clr_fin;
        clr_cnt_d   = clr_ok ? '0 : clr_go ? clr_cnt_q + 1'b1 : clr_cnt_q;
        clr_all_d   = clr_ok ? 1'b0 : (clr_go && clr_cnt_q == CLR_LAST) ? 1'b1 : clr_all_q;
        clr_color_d = clr_ok ? clr_color : clr_color_q;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
            vid_pend_q  <= 1'b0;
            vid_paddr_q <= '0;
            vid_ovf_q   <= 1'b0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
            clr_all_q   <= 1'b0;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            wr_clr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            vid_data_q  <= vid_data_d;
            vid_valid_q <= vid_valid_d;
            vid_pend_q  <= vid_pend_d;
            vid_paddr_q <= vid_paddr_d;
            vid_ovf_q   <= vid_ovf_d;
            clr_busy_q  <= clr_busy_d;
            clr_done_q  <= clr_done_d;
            clr_all_q   <= clr_all_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
            wr_clr_q    <= wr_clr_d;
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign vid_data  = vid_data_q;
    assign vid_valid = vid_valid_q;
    assign vid_ovf   = vid_ovf_q;
    assign clr_busy  = clr_busy_q;
    assign clr_done  = clr_done_q;
endmodule
